// File: rtl/alarm_ring_ctrl_pkg.sv
// alarm_ring_ctrl_pkg
// Shared definitions for the alarm ring controller slice:
//   - 17-bit time-bus layout (meridian / hour / minute / second)
//   - UI mode (FLAG) encodings
//   - ALARM_STATE encodings used by the ring FSM
//   - make_time(): packs the time-bus fields into one word
package alarm_ring_ctrl_pkg;

  localparam int TIME_W       = 17;
  localparam int MERIDIAN_BIT = 16;
  localparam int HOUR_MSB     = 15;
  localparam int HOUR_LSB     = 12;
  localparam int MIN_MSB      = 11;
  localparam int MIN_LSB      = 6;
  localparam int SEC_MSB      = 5;
  localparam int SEC_LSB      = 0;

  localparam logic [2:0] FLAG_ALARM_CONTROL_STATE = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RINGING  = 2'b01,
    ST_SNOOZING = 2'b10
  } alarm_state_e;

  function automatic logic [TIME_W-1:0] make_time(input logic       pm,
                                                  input logic [3:0] hour,
                                                  input logic [5:0] minute,
                                                  input logic [5:0] second);
    logic [TIME_W-1:0] t;
    t                        = '0;
    t[MERIDIAN_BIT]          = pm;
    t[HOUR_MSB:HOUR_LSB]     = hour;
    t[MIN_MSB:MIN_LSB]       = minute;
    t[SEC_MSB:SEC_LSB]       = second;
    return t;
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// alarm_ring_ctrl_if
// Signal bundle between the time/alarm-setting side and the ring controller.
//   master: drives TICK_1HZ, CUR_TIME, ALARM_TIME, ALARM_EN, FLAG, STOP, SNOOZE;
//           observes RING, ALARM_STATE, SNOOZE_CNT
//   slave : the ring controller (inverse directions)
interface alarm_ring_ctrl_if;
  import alarm_ring_ctrl_pkg::*;

  logic              TICK_1HZ;
  logic [TIME_W-1:0] CUR_TIME;
  logic [TIME_W-1:0] ALARM_TIME;
  logic              ALARM_EN;
  logic [2:0]        FLAG;
  logic              STOP;
  logic              SNOOZE;
  logic              RING;
  logic [1:0]        ALARM_STATE;
  logic [2:0]        SNOOZE_CNT;

  modport master (
    output TICK_1HZ, CUR_TIME, ALARM_TIME, ALARM_EN, FLAG, STOP, SNOOZE,
    input  RING, ALARM_STATE, SNOOZE_CNT
  );

  modport slave (
    input  TICK_1HZ, CUR_TIME, ALARM_TIME, ALARM_EN, FLAG, STOP, SNOOZE,
    output RING, ALARM_STATE, SNOOZE_CNT
  );

endinterface

// File: rtl/alarm_tick_timer.sv
// alarm_tick_timer
// Tick counter with synchronous clear and count enable. tc flags the enabled
// tick on which the count sits at 'last' (period-1); that tick wraps the count
// back to 0, so the count never exceeds period-1.
//   clk  : clock
//   rst  : synchronous active-high reset
//   clr  : clear count to 0 (wins over en)
//   en   : count one tick
//   last : terminal value (period-1), may change between uses
//   tc   : terminal-count tick (combinational from count, en, last)
module alarm_tick_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;

  assign tc = en && (count_q == last);

  always_ff @(posedge clk) begin
    if (rst || clr || tc) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl
// Detects the alarm-time match and runs the IDLE / RINGING / SNOOZING FSM that
// drives the buzzer enable.
//   CLK    : system clock
//   RESETN : synchronous reset, asserted = 1
//   bus    : alarm_ring_ctrl_if.slave
//            in : TICK_1HZ, CUR_TIME, ALARM_TIME, ALARM_EN, FLAG, STOP, SNOOZE
//            out: RING, ALARM_STATE, SNOOZE_CNT (all from registered state)
module alarm_ring_ctrl
  import alarm_ring_ctrl_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic               CLK,
  input  logic               RESETN,
  alarm_ring_ctrl_if.slave   bus
);

  localparam int MAX_SEC = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int TMR_W   = (MAX_SEC > 1) ? $clog2(MAX_SEC) : 1;

  alarm_state_e     state_q, state_n;
  logic             match, match_q, trigger;
  logic [2:0]       snz_cnt_q, snz_cnt_n;
  logic             tmr_clr, tmr_en, tmr_tc;
  logic [TMR_W-1:0] tmr_last;

  // Edit mode suppresses the match so changing ALARM_TIME cannot fire the alarm.
  assign match   = bus.ALARM_EN && (bus.FLAG != FLAG_ALARM_CONTROL_STATE) &&
                   (bus.CUR_TIME == bus.ALARM_TIME);
  // Equality persists for a whole second; only the rising edge fires.
  assign trigger = match && !match_q;

  // One timer serves both periods; only the terminal value changes with state.
  assign tmr_last = (state_q == ST_RINGING) ? TMR_W'(RING_SEC - 1)
                                            : TMR_W'(SNOOZE_SEC - 1);

  alarm_tick_timer #(.CNT_W(TMR_W)) u_timer (
    .clk  (CLK),
    .rst  (RESETN),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .last (tmr_last),
    .tc   (tmr_tc)
  );

  always_ff @(posedge CLK) begin
    if (RESETN) begin
      state_q   <= ST_IDLE;
      match_q   <= 1'b0;
      snz_cnt_q <= '0;
    end else begin
      state_q   <= state_n;
      match_q   <= match;
      snz_cnt_q <= snz_cnt_n;
    end
  end

  // Priority: ALARM_EN low, then STOP, then SNOOZE, then timer expiry.
  always_comb begin
    state_n   = state_q;
    snz_cnt_n = snz_cnt_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    if (!bus.ALARM_EN) begin
      state_n = ST_IDLE;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_n   = ST_RINGING;
            snz_cnt_n = '0;
            tmr_clr   = 1'b1;
          end
        end
        ST_RINGING: begin
          if (bus.STOP) begin
            state_n   = ST_IDLE;
            snz_cnt_n = '0;
            tmr_clr   = 1'b1;
          end else if (bus.SNOOZE && (snz_cnt_q < 3'(MAX_SNOOZE))) begin
            state_n   = ST_SNOOZING;
            snz_cnt_n = snz_cnt_q + 3'd1;
            tmr_clr   = 1'b1;
          end else begin
            // A saturated SNOOZE falls through here and ringing continues.
            tmr_en = bus.TICK_1HZ;
            if (tmr_tc) begin
              state_n = ST_IDLE;
            end
          end
        end
        ST_SNOOZING: begin
          if (bus.STOP) begin
            state_n   = ST_IDLE;
            snz_cnt_n = '0;
            tmr_clr   = 1'b1;
          end else begin
            tmr_en = bus.TICK_1HZ;
            if (tmr_tc) begin
              state_n = ST_RINGING;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  assign bus.RING        = (state_q == ST_RINGING);
  assign bus.ALARM_STATE = state_q;
  assign bus.SNOOZE_CNT  = snz_cnt_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl
// Directed-vector bench for alarm_ring_ctrl with RING_SEC=4, SNOOZE_SEC=5,
// MAX_SNOOZE=2. Inputs change 1 ns after a rising edge; outputs are checked
// at the same point, i.e. they reflect the state after that edge.
module tb_alarm_ring_ctrl;
  import alarm_ring_ctrl_pkg::*;

  localparam int RING_SEC   = 4;
  localparam int SNOOZE_SEC = 5;
  localparam int MAX_SNOOZE = 2;

  logic CLK;
  logic RESETN;
  int   n_vec;
  int   n_miss;

  logic [TIME_W-1:0] t_alarm;
  logic [TIME_W-1:0] t_before;

  alarm_ring_ctrl_if bus ();

  alarm_ring_ctrl #(
    .RING_SEC   (RING_SEC),
    .SNOOZE_SEC (SNOOZE_SEC),
    .MAX_SNOOZE (MAX_SNOOZE)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    bus.TICK_1HZ = 1'b1;
    step();
    bus.TICK_1HZ = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      tick();
    end
  endtask

  task automatic chk_out(input string tag, input int ring, input int st, input int cnt);
    chk({tag, ".ring"},  int'(bus.RING),        ring);
    chk({tag, ".state"}, int'(bus.ALARM_STATE), st);
    chk({tag, ".cnt"},   int'(bus.SNOOZE_CNT),  cnt);
  endtask

  // Drive CUR_TIME away and then onto the alarm time; one edge later it rings.
  task automatic start_ring(input string tag);
    bus.CUR_TIME = t_before;
    step();
    bus.CUR_TIME = t_alarm;
    step();
    chk({tag, ".start"}, int'(bus.RING), 1);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    t_alarm  = make_time(1'b1, 4'd7, 6'd30, 6'd0);
    t_before = make_time(1'b1, 4'd7, 6'd29, 6'd59);

    bus.TICK_1HZ   = 1'b0;
    bus.CUR_TIME   = t_before;
    bus.ALARM_TIME = t_alarm;
    bus.ALARM_EN   = 1'b1;
    bus.FLAG       = 3'b000;
    bus.STOP       = 1'b0;
    bus.SNOOZE     = 1'b0;
    RESETN         = 1'b1;
    step();
    step();
    chk_out("reset", 0, 0, 0);
    RESETN = 1'b0;
    step();
    chk_out("after_reset", 0, 0, 0);

    // Match fires once, rings exactly 4 ticks, no retrigger while held equal.
    bus.CUR_TIME = t_alarm;
    chk("pre_edge.ring", int'(bus.RING), 0);
    step();
    chk_out("trigger", 1, 1, 0);
    step();
    step();
    step();
    chk_out("hold_equal", 1, 1, 0);
    idle_ticks(3);
    chk_out("ring_tick3", 1, 1, 0);
    idle_ticks(1);
    chk_out("ring_tick4", 0, 0, 0);
    step();
    step();
    chk_out("no_retrigger", 0, 0, 0);

    // Snooze, then re-ring after exactly 5 ticks.
    start_ring("snz");
    bus.SNOOZE = 1'b1;
    step();
    bus.SNOOZE = 1'b0;
    chk_out("snooze1", 0, 2, 1);
    idle_ticks(4);
    chk_out("snooze_tick4", 0, 2, 1);
    idle_ticks(1);
    chk_out("snooze_tick5", 1, 1, 1);

    // Second snooze, re-ring, third snooze ignored at the limit.
    bus.SNOOZE = 1'b1;
    step();
    bus.SNOOZE = 1'b0;
    chk_out("snooze2", 0, 2, 2);
    idle_ticks(5);
    chk_out("rering2", 1, 1, 2);
    bus.SNOOZE = 1'b1;
    step();
    bus.SNOOZE = 1'b0;
    chk_out("snooze3_ignored", 1, 1, 2);

    // STOP beats SNOOZE in the same cycle.
    bus.STOP   = 1'b1;
    bus.SNOOZE = 1'b1;
    step();
    bus.STOP   = 1'b0;
    bus.SNOOZE = 1'b0;
    chk_out("stop_snooze", 0, 0, 0);

    // Edit mode masks the match.
    bus.CUR_TIME = t_before;
    step();
    bus.FLAG     = FLAG_ALARM_CONTROL_STATE;
    bus.CUR_TIME = t_alarm;
    step();
    step();
    chk_out("edit_no_ring", 0, 0, 0);
    bus.CUR_TIME = t_before;
    step();
    bus.FLAG = 3'b000;
    step();

    // Entering edit mode does not stop an active alarm.
    start_ring("edit_active");
    bus.FLAG = FLAG_ALARM_CONTROL_STATE;
    step();
    chk_out("edit_keeps_ring", 1, 1, 0);
    bus.FLAG     = 3'b000;
    bus.CUR_TIME = t_before;
    bus.STOP     = 1'b1;
    step();
    bus.STOP = 1'b0;
    chk_out("stop_ring", 0, 0, 0);

    // ALARM_EN low mid-ring.
    start_ring("en_off");
    bus.ALARM_EN = 1'b0;
    step();
    chk("en_off.ring",  int'(bus.RING), 0);
    chk("en_off.state", int'(bus.ALARM_STATE), 0);
    bus.CUR_TIME = t_before;
    step();
    bus.ALARM_EN = 1'b1;
    step();

    // Back-to-back ticks each count.
    start_ring("burst");
    bus.TICK_1HZ = 1'b1;
    step();
    step();
    step();
    chk_out("burst_tick3", 1, 1, 0);
    step();
    bus.TICK_1HZ = 1'b0;
    chk_out("burst_tick4", 0, 0, 0);

    // Reset during snooze; later expiry must not ring.
    start_ring("rst_snz");
    bus.SNOOZE = 1'b1;
    step();
    bus.SNOOZE = 1'b0;
    chk_out("rst_snz.snoozing", 0, 2, 1);
    idle_ticks(2);
    RESETN = 1'b1;
    step();
    chk_out("rst_snz.reset", 0, 0, 0);
    bus.CUR_TIME = t_before;
    RESETN = 1'b0;
    idle_ticks(6);
    chk_out("rst_snz.no_expiry", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
